play_area_sched: RTL and testbench

// Owns the single port of the play_area cell RAM and schedules every access to it.

---
 rtl/play_area_sched.sv | 177 +++++++++++++++++
 tb/tb_play_area_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/play_area_sched.sv
// play_area_sched: single-port arbiter for the play_area cell RAM.
// Clients, highest priority first: clear sequencer, VGA scanout, game request port.
// Optional stall statistics counter is enabled with `define SCHED_STATS_EN.
module play_area_sched #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 60,
  parameter int unsigned DATA_W = 3,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
  localparam int unsigned XW = $clog2(COLS),
  localparam int unsigned YW = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear_start,
  output logic              o_clear_busy,
  output logic              o_clear_done,
  input  logic              i_scan_active,
  input  logic [XW-1:0]     i_scan_x,
  input  logic [YW-1:0]     i_scan_y,
  output logic [DATA_W-1:0] o_scan_data,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [XW-1:0]     i_req_x,
  input  logic [YW-1:0]     i_req_y,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
`ifdef SCHED_STATS_EN
  output logic [15:0]       o_stall_count,
`endif
  output logic [XW-1:0]     o_ram_x,
  output logic [YW-1:0]     o_ram_y,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e        r_state, w_state_next;
  logic [XW-1:0] r_clr_x, w_clr_x_next;
  logic [YW-1:0] r_clr_y, w_clr_y_next;
  logic          r_clear_done, w_clear_done_next;
  logic          r_scan_rd, w_scan_rd_next;
  logic          r_rsp_pend, w_rsp_pend_next;
  logic          r_rsp_oob, w_rsp_oob_next;
  logic [XW-1:0] r_last_x;
  logic [YW-1:0] r_last_y;

  logic w_req_in_range;
  logic w_clr_last_x;
  logic w_clr_last_y;

  assign w_req_in_range = (i_req_x < XW'(COLS)) && (i_req_y < YW'(ROWS));
  assign w_clr_last_x   = (r_clr_x == XW'(COLS - 1));
  assign w_clr_last_y   = (r_clr_y == YW'(ROWS - 1));

  // Next-state and RAM port arbitration.
  always_comb begin
    w_state_next      = r_state;
    w_clr_x_next      = r_clr_x;
    w_clr_y_next      = r_clr_y;
    w_clear_done_next = 1'b0;
    w_scan_rd_next    = 1'b0;
    w_rsp_pend_next   = 1'b0;
    w_rsp_oob_next    = 1'b0;
    o_ram_x           = r_last_x;
    o_ram_y           = r_last_y;
    o_ram_we          = 1'b0;
    o_ram_wdata       = '0;
    o_req_ready       = 1'b0;

    unique case (r_state)
      StClear: begin
        o_ram_x     = r_clr_x;
        o_ram_y     = r_clr_y;
        o_ram_we    = 1'b1;
        o_ram_wdata = CLEAR_VALUE;
        if (w_clr_last_x) begin
          w_clr_x_next = '0;
          if (w_clr_last_y) begin
            w_clr_y_next      = '0;
            w_state_next      = StRun;
            w_clear_done_next = 1'b1;
          end else begin
            w_clr_y_next = r_clr_y + 1'b1;
          end
        end else begin
          w_clr_x_next = r_clr_x + 1'b1;
        end
      end
      StRun: begin
        if (i_clear_start) begin
          w_state_next = StClear;
          w_clr_x_next = '0;
          w_clr_y_next = '0;
        end
        if (i_scan_active) begin
          o_ram_x        = i_scan_x;
          o_ram_y        = i_scan_y;
          w_scan_rd_next = 1'b1;
        end else if (!i_clear_start) begin
          o_req_ready = 1'b1;
          if (i_req_valid) begin
            o_ram_x = i_req_x;
            o_ram_y = i_req_y;
            if (i_req_write) begin
              // Out-of-range writes are accepted but never reach the RAM.
              o_ram_we    = w_req_in_range;
              o_ram_wdata = i_req_wdata;
            end else begin
              w_rsp_pend_next = 1'b1;
              w_rsp_oob_next  = !w_req_in_range;
            end
          end
        end
      end
    endcase

    // Reset is synchronous, so the reset cycle itself must be kept quiet.
    if (reset) begin
      o_ram_we    = 1'b0;
      o_req_ready = 1'b0;
    end
  end

  // State, clear pointer, read tracking and held address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StClear;
      r_clr_x      <= '0;
      r_clr_y      <= '0;
      r_clear_done <= 1'b0;
      r_scan_rd    <= 1'b0;
      r_rsp_pend   <= 1'b0;
      r_rsp_oob    <= 1'b0;
      r_last_x     <= '0;
      r_last_y     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_clr_x      <= w_clr_x_next;
      r_clr_y      <= w_clr_y_next;
      r_clear_done <= w_clear_done_next;
      r_scan_rd    <= w_scan_rd_next;
      r_rsp_pend   <= w_rsp_pend_next;
      r_rsp_oob    <= w_rsp_oob_next;
      r_last_x     <= o_ram_x;
      r_last_y     <= o_ram_y;
    end
  end

  // Status and read-data outputs, all forced idle in the reset cycle.
  always_comb begin
    o_clear_busy = reset || (r_state == StClear);
    o_clear_done = r_clear_done && !reset;
    o_rsp_valid  = r_rsp_pend && !reset;
    o_rsp_rdata  = (o_rsp_valid && !r_rsp_oob) ? i_ram_rdata : '0;
    o_scan_data  = (r_scan_rd && (r_state == StRun) && !reset) ? i_ram_rdata : '0;
  end

`ifdef SCHED_STATS_EN
  logic [15:0] r_stall_count;

  // Saturating count of cycles a request waited without being accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (i_req_valid && !o_req_ready && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_play_area_sched.sv
// Testbench for play_area_sched: directed vector table plus clear/reset sequences.
// Includes a behavioural RAM with one-cycle read latency.
module tb_play_area_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_start, clear_busy, clear_done;
  logic       scan_active;
  logic [6:0] scan_x;
  logic [5:0] scan_y;
  logic [2:0] scan_data;
  logic       req_valid, req_ready, req_write;
  logic [6:0] req_x;
  logic [5:0] req_y;
  logic [2:0] req_wdata;
  logic       rsp_valid;
  logic [2:0] rsp_rdata;
  logic [6:0] ram_x;
  logic [5:0] ram_y;
  logic       ram_we;
  logic [2:0] ram_wdata;
  logic [2:0] ram_rdata;
`ifdef SCHED_STATS_EN
  logic [15:0] stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  play_area_sched dut (
    .clk          (clk),
    .reset        (reset),
    .i_clear_start(clear_start),
    .o_clear_busy (clear_busy),
    .o_clear_done (clear_done),
    .i_scan_active(scan_active),
    .i_scan_x     (scan_x),
    .i_scan_y     (scan_y),
    .o_scan_data  (scan_data),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_x      (req_x),
    .i_req_y      (req_y),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
`ifdef SCHED_STATS_EN
    .o_stall_count(stall_count),
`endif
    .o_ram_x      (ram_x),
    .o_ram_y      (ram_y),
    .o_ram_we     (ram_we),
    .o_ram_wdata  (ram_wdata),
    .i_ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: read-first, out-of-range addresses read back 3'b111.
  logic [2:0] mem [0:4799];
  initial for (int i = 0; i < 4800; i++) mem[i] = 3'b110;
  always @(posedge clk) begin
    if (ram_x < 7'd80 && ram_y < 6'd60) begin
      ram_rdata <= mem[int'(ram_y) * 80 + int'(ram_x)];
      if (ram_we) mem[int'(ram_y) * 80 + int'(ram_x)] <= ram_wdata;
    end else begin
      ram_rdata <= 3'b111;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic sa, input logic [6:0] sx, input logic [5:0] sy,
                       input logic rv, input logic rw, input logic [6:0] rx,
                       input logic [5:0] ry, input logic [2:0] wd);
    scan_active = sa; scan_x = sx; scan_y = sy;
    req_valid = rv; req_write = rw; req_x = rx; req_y = ry; req_wdata = wd;
  endtask

  // One clear pass. pulse_at: write index at which clear_start is pulsed (ignored by DUT).
  // abort_at: write index at which reset is asserted and the task returns.
  task automatic clear_sweep(input int pulse_at, input int abort_at);
    int  n = 0;
    bit  order_err = 0, ready_err = 0, scan_err = 0, done_seen = 0;
    for (int cyc = 0; cyc < 5000 && !done_seen; cyc++) begin
      @(negedge clk);
      reset       = (abort_at >= 0 && n == abort_at);
      clear_start = (n == pulse_at);
      drive((cyc % 2) == 1, 7'd77, 6'd1, 1'b1, 1'b0, 7'd0, 6'd0, 3'd0);
      #2;
      if (reset) begin
        chk("abort_we", ram_we, 0);
        chk("abort_busy", clear_busy, 1);
        chk("abort_ready", req_ready, 0);
        chk("abort_done", clear_done, 0);
        return;
      end
      if (ram_we) begin
        if (ram_x !== 7'(n % 80) || ram_y !== 6'(n / 80) || ram_wdata !== 3'd0 ||
            clear_done !== 1'b0 || clear_busy !== 1'b1) begin
          if (!order_err)
            $display("FAIL clear_write_%0d: got (%0d,%0d) expected (%0d,%0d)",
                     n, ram_x, ram_y, n % 80, n / 80);
          order_err = 1;
        end
        if (req_ready !== 1'b0) ready_err = 1;
        if (scan_data !== 3'd0) scan_err = 1;
        n++;
      end else begin
        done_seen = 1;
        chk("clear_done_pulse", clear_done, 1);
        chk("clear_busy_end", clear_busy, 0);
      end
    end
    chk("clear_write_count", n, 4800);
    chk("clear_order_ok", order_err, 0);
    chk("clear_ready_low", ready_err, 0);
    chk("clear_scan_zero", scan_err, 0);
    @(negedge clk);
    clear_start = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("clear_done_single", clear_done, 0);
  endtask

  typedef struct {
    logic       sa;
    logic [6:0] sx;
    logic [5:0] sy;
    logic       rv, rw;
    logic [6:0] rx;
    logic [5:0] ry;
    logic [2:0] wd;
    logic       e_ready, e_we;
    logic [6:0] e_x;
    logic [5:0] e_y;
    logic       e_rspv;
    logic [2:0] e_rspd, e_scan;
  } vec_t;

  vec_t vt [14];

  initial begin
    // sa  sx     sy    rv rw  rx     ry     wd   | rdy we ex     ey     rv rd  scan
    vt[0]  = '{0, 7'd0,   6'd0,  0, 0, 7'd0,  6'd0,  3'd0, 1, 0, 7'd0,   6'd0,  0, 0, 0};
    vt[1]  = '{0, 7'd0,   6'd0,  1, 1, 7'd5,  6'd7,  3'd5, 1, 1, 7'd5,   6'd7,  0, 0, 0};
    vt[2]  = '{0, 7'd0,   6'd0,  1, 1, 7'd12, 6'd3,  3'd3, 1, 1, 7'd12,  6'd3,  0, 0, 0};
    vt[3]  = '{0, 7'd0,   6'd0,  1, 0, 7'd5,  6'd7,  3'd0, 1, 0, 7'd5,   6'd7,  0, 0, 0};
    vt[4]  = '{1, 7'd12,  6'd3,  1, 0, 7'd5,  6'd7,  3'd0, 0, 0, 7'd12,  6'd3,  1, 5, 0};
    vt[5]  = '{0, 7'd12,  6'd3,  1, 0, 7'd12, 6'd3,  3'd0, 1, 0, 7'd12,  6'd3,  0, 0, 3};
    vt[6]  = '{0, 7'd0,   6'd0,  1, 0, 7'd80, 6'd0,  3'd0, 1, 0, 7'd80,  6'd0,  1, 3, 0};
    vt[7]  = '{0, 7'd0,   6'd0,  1, 1, 7'd10, 6'd60, 3'd7, 1, 0, 7'd10,  6'd60, 1, 0, 0};
    vt[8]  = '{1, 7'd100, 6'd50, 0, 0, 7'd0,  6'd0,  3'd0, 0, 0, 7'd100, 6'd50, 0, 0, 0};
    vt[9]  = '{0, 7'd0,   6'd0,  0, 0, 7'd0,  6'd0,  3'd0, 1, 0, 7'd100, 6'd50, 0, 0, 7};
    vt[10] = '{0, 7'd0,   6'd0,  1, 0, 7'd5,  6'd7,  3'd0, 1, 0, 7'd5,   6'd7,  0, 0, 0};
    vt[11] = '{0, 7'd0,   6'd0,  1, 0, 7'd12, 6'd3,  3'd0, 1, 0, 7'd12,  6'd3,  1, 5, 0};
    vt[12] = '{0, 7'd0,   6'd0,  1, 0, 7'd79, 6'd59, 3'd0, 1, 0, 7'd79,  6'd59, 1, 3, 0};
    vt[13] = '{0, 7'd0,   6'd0,  0, 0, 7'd0,  6'd0,  3'd0, 1, 0, 7'd79,  6'd59, 1, 0, 0};
  end

  initial begin
    reset = 1;
    clear_start = 0;
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    // Reset state with a pending request.
    repeat (2) @(negedge clk);
    #2;
    chk("rst_we", ram_we, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_busy", clear_busy, 1);
    chk("rst_scan", scan_data, 0);
`ifdef SCHED_STATS_EN
    chk("rst_stall", stall_count, 0);
`endif

    // Power-up clear.
    clear_sweep(-1, -1);

    // Directed vectors in RUN.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vt[i].sa, vt[i].sx, vt[i].sy, vt[i].rv, vt[i].rw, vt[i].rx, vt[i].ry, vt[i].wd);
      #2;
      chk($sformatf("v%0d_ready", i), req_ready, vt[i].e_ready);
      chk($sformatf("v%0d_we", i), ram_we, vt[i].e_we);
      chk($sformatf("v%0d_x", i), ram_x, vt[i].e_x);
      chk($sformatf("v%0d_y", i), ram_y, vt[i].e_y);
      chk($sformatf("v%0d_rspv", i), rsp_valid, vt[i].e_rspv);
      chk($sformatf("v%0d_rspd", i), rsp_rdata, vt[i].e_rspd);
      chk($sformatf("v%0d_scan", i), scan_data, vt[i].e_scan);
      if (vt[i].e_we) chk($sformatf("v%0d_wdata", i), ram_wdata, vt[i].wd);
    end
    chk("oob_write_dropped", mem[10], 3'd0);

    // Read accepted the cycle before clear_start still responds; clear_start blocks ready.
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 7'd5, 6'd7, 0);
    #2;
    chk("pre_clr_ready", req_ready, 1);
    @(negedge clk);
    clear_start = 1;
    #2;
    chk("clr_start_ready", req_ready, 0);
    chk("clr_start_rspv", rsp_valid, 1);
    chk("clr_start_rspd", rsp_rdata, 5);
    chk("clr_start_busy", clear_busy, 0);
    // Re-clear with a clear_start pulse mid-sweep that must be ignored.
    clear_sweep(100, -1);

    // In-flight read dropped by reset, then clear aborted at write 2000 and restarted.
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 7'd5, 6'd7, 0);
    #2;
    chk("pre_rst_ready", req_ready, 1);
    @(negedge clk);
    reset = 1;
    #2;
    chk("rst_drop_rspv", rsp_valid, 0);
    clear_sweep(-1, 2000);
    clear_sweep(-1, -1);

    // Cleared cell reads back as zero after the restarted clear.
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 7'd5, 6'd7, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("post_clear_rspv", rsp_valid, 1);
    chk("post_clear_rspd", rsp_rdata, 0);

`ifdef SCHED_STATS_EN
    begin
      logic [15:0] s0;
      s0 = stall_count;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        drive(1, 7'd1, 6'd1, 1, 0, 0, 0, 0);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("stall_count", stall_count, 32'(s0) + 32'd10);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
